flash_sample_sequencer: RTL and testbench

- Fetch stage that issues Avalon-MM reads to the flash controller on 22 kHz sample ticks.
- Splits each 32-bit flash word into two 16-bit audio samples and presents them, one per tick, to the audio output path.
- Owns the playback address: forward/backward direction, wrap, pause and restart.
- Sits between the synced 22 kHz tick source and the audio DAC interface, and drives the flash controller's read port.

---
 rtl/flash_sample_sequencer.sv | 137 +++++++++++++
 tb/tb_flash_sample_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_sequencer.sv
// Flash fetch stage: on each 22 kHz tick, read a 32-bit flash word over Avalon-MM and
// emit its two 16-bit halves as audio samples, one per tick.
module flash_sample_sequencer #(
    parameter int unsigned       ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 'h7FFFF
) (
    input  logic              i_clk_50,
    input  logic              i_reset_n,
    input  logic              i_sample_tick,
    input  logic              i_play,
    input  logic              i_dir,
    input  logic              i_restart,
    output logic [ADDR_W-1:0] o_flash_address,
    output logic              o_flash_read,
    input  logic              i_flash_waitrequest,
    input  logic [31:0]       i_flash_readdata,
    input  logic              i_flash_readdatavalid,
    output logic [15:0]       o_audio_sample,
    output logic              o_sample_valid,
    output logic              o_overrun,
    output logic              o_busy
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitData, StEmit} state_e;

    state_e            r_state,          w_state_d;
    logic [ADDR_W-1:0] r_addr,           w_addr_d;
    logic              r_half_sel,       w_half_sel_d;
    logic              r_tick_pending,   w_tick_pending_d;
    logic              r_restart_pending, w_restart_pending_d;
    logic              r_word_dir,       w_word_dir_d;
    logic [31:0]       r_word_buf,       w_word_buf_d;
    logic [15:0]       r_audio_sample,   w_audio_sample_d;
    logic              r_overrun,        w_overrun_d;

    logic w_restart_req;
    logic w_consume;
    logic w_restart_apply;

    always_ff @(posedge i_clk_50) begin
        if (!i_reset_n) begin
            r_state           <= StIdle;
            r_addr            <= '0;
            r_half_sel        <= 1'b0;
            r_tick_pending    <= 1'b0;
            r_restart_pending <= 1'b0;
            r_word_dir        <= 1'b0;
            r_word_buf        <= '0;
            r_audio_sample    <= '0;
            r_overrun         <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_addr            <= w_addr_d;
            r_half_sel        <= w_half_sel_d;
            r_tick_pending    <= w_tick_pending_d;
            r_restart_pending <= w_restart_pending_d;
            r_word_dir        <= w_word_dir_d;
            r_word_buf        <= w_word_buf_d;
            r_audio_sample    <= w_audio_sample_d;
            r_overrun         <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d           = r_state;
        w_addr_d            = r_addr;
        w_half_sel_d        = r_half_sel;
        w_restart_pending_d = r_restart_pending;
        w_word_dir_d        = r_word_dir;
        w_word_buf_d        = r_word_buf;
        w_audio_sample_d    = r_audio_sample;
        w_consume           = 1'b0;
        w_restart_apply     = 1'b0;
        w_restart_req       = i_restart | r_restart_pending;

        unique case (r_state)
            StIdle: begin
                if (w_restart_req) begin
                    w_restart_apply     = 1'b1;
                    w_restart_pending_d = 1'b0;
                    w_half_sel_d        = 1'b0;
                    w_addr_d            = i_dir ? '0 : MAX_ADDR;
                end else if (r_tick_pending && i_play) begin
                    w_consume = 1'b1;
                    if (!r_half_sel) begin
                        w_state_d    = StReq;
                        w_word_dir_d = i_dir;
                    end else begin
                        // Second half comes from the buffer, so the sample is loaded on entry to EMIT
                        w_state_d        = StEmit;
                        w_audio_sample_d = r_word_dir ? r_word_buf[31:16] : r_word_buf[15:0];
                    end
                end
            end
            StReq: begin
                if (i_restart) w_restart_pending_d = 1'b1;
                if (!i_flash_waitrequest) w_state_d = StWaitData;
            end
            StWaitData: begin
                if (i_restart) w_restart_pending_d = 1'b1;
                if (i_flash_readdatavalid) begin
                    if (w_restart_req) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d        = StEmit;
                        w_word_buf_d     = i_flash_readdata;
                        w_audio_sample_d = r_word_dir ? i_flash_readdata[15:0]
                                                      : i_flash_readdata[31:16];
                    end
                end
            end
            StEmit: begin
                if (i_restart) w_restart_pending_d = 1'b1;
                w_state_d = StIdle;
                if (!r_half_sel) begin
                    w_half_sel_d = 1'b1;
                end else begin
                    w_half_sel_d = 1'b0;
                    if (i_dir) w_addr_d = (r_addr == MAX_ADDR) ? '0 : r_addr + 1'b1;
                    else       w_addr_d = (r_addr == '0) ? MAX_ADDR : r_addr - 1'b1;
                end
            end
        endcase

        // A tick landing on a still-pending, unconsumed tick is lost
        w_overrun_d      = i_sample_tick & r_tick_pending & ~w_consume & ~w_restart_apply;
        w_tick_pending_d = i_sample_tick | (r_tick_pending & ~w_consume & ~w_restart_apply);
    end

    assign o_flash_address = r_addr;
    assign o_flash_read    = (r_state == StReq);
    assign o_sample_valid  = (r_state == StEmit);
    assign o_busy          = (r_state != StIdle);
    assign o_audio_sample  = r_audio_sample;
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Scoreboard bench: stimulus pushes expected read addresses and samples; a flash responder
// and an output monitor pop and compare as the DUT presents them.
module tb_flash_sample_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        play;
    logic        dir;
    logic        restart;
    logic [22:0] flash_address;
    logic        flash_read;
    logic        waitreq;
    logic [31:0] rdata;
    logic        rdv;
    logic [15:0] audio;
    logic        sv;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [22:0] exp_addr_q[$];
    logic [15:0] exp_smp_q[$];
    logic [31:0] rd_word  = '0;
    int          rdv_extra = 0;

    int sv_cnt = 0, ovr_cnt = 0, rd_hi = 0, acc_cnt = 0, addr_moves = 0;
    int sv_exp = 0;

    flash_sample_sequencer dut (
        .i_clk_50              (clk),
        .i_reset_n             (rst_n),
        .i_sample_tick         (tick),
        .i_play                (play),
        .i_dir                 (dir),
        .i_restart             (restart),
        .o_flash_address       (flash_address),
        .o_flash_read          (flash_read),
        .i_flash_waitrequest   (waitreq),
        .i_flash_readdata      (rdata),
        .i_flash_readdatavalid (rdv),
        .o_audio_sample        (audio),
        .o_sample_valid        (sv),
        .o_overrun             (overrun),
        .o_busy                (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: samples, pulse counts, read-cycle counts and address stability
    initial begin
        logic        prev_rd;
        logic [22:0] prev_addr;
        prev_rd = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sv) begin
                    sv_cnt++;
                    if (exp_smp_q.size() == 0) chk("unexpected_sample", {16'h0, audio}, 32'hFFFF_FFFF);
                    else chk("sample", {16'h0, audio}, {16'h0, exp_smp_q.pop_front()});
                end
                if (overrun) ovr_cnt++;
                if (flash_read) begin
                    rd_hi++;
                    if (prev_rd && flash_address != prev_addr) addr_moves++;
                    if (!waitreq) acc_cnt++;
                end
                prev_rd   = flash_read;
                prev_addr = flash_address;
            end
        end
    end

    // Flash responder: checks each accepted read address, returns rd_word after rdv_extra cycles
    initial begin
        rdv   = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && flash_read && !waitreq) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", {9'h0, flash_address}, 32'hFFFF_FFFF);
                else chk("read_addr", {9'h0, flash_address}, {9'h0, exp_addr_q.pop_front()});
                @(posedge clk);
                #1;
                repeat (rdv_extra) begin
                    @(posedge clk);
                    #1;
                end
                rdv   = 1'b1;
                rdata = rd_word;
                @(posedge clk);
                #1;
                rdv   = 1'b0;
                rdata = 32'h5A5A_5A5A;
            end
        end
    end

    task automatic wait_sv(input string name);
        for (int i = 0; i < 100 && sv_cnt < sv_exp; i++) step(1);
        chk(name, sv_cnt, sv_exp);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(1);
    endtask

    // One word: fetched half on the first tick, buffered half on the second
    task automatic fetch_pair(input logic [22:0] a, input logic [31:0] w, input logic d);
        dir     = d;
        rd_word = w;
        exp_addr_q.push_back(a);
        exp_smp_q.push_back(d ? w[15:0] : w[31:16]);
        exp_smp_q.push_back(d ? w[31:16] : w[15:0]);
        pulse_tick();
        sv_exp++;
        wait_sv("sv_first_half");
        pulse_tick();
        sv_exp++;
        wait_sv("sv_second_half");
    endtask

    initial begin
        int acc0, ovr0, sv0;
        rst_n   = 1'b0;
        tick    = 1'b0;
        play    = 1'b1;
        dir     = 1'b1;
        restart = 1'b0;
        waitreq = 1'b0;
        step(3);
        chk("rst_read",    {31'h0, flash_read}, 32'h0);
        chk("rst_address", {9'h0, flash_address}, 32'h0);
        chk("rst_audio",   {16'h0, audio}, 32'h0);
        chk("rst_valid",   {31'h0, sv}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_busy",    {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        step(2);

        // Forward from reset: 1234 then BEEF, one read, addr advances to 1
        acc0 = acc_cnt;
        fetch_pair(23'h0, 32'hBEEF_1234, 1'b1);
        step(3);
        chk("fwd_addr_after", {9'h0, flash_address}, 32'h1);
        chk("fwd_one_read", acc_cnt - acc0, 1);

        // Backward after restart: read at MAX, AAAA then 5555, addr 7FFFE
        dir = 1'b0;
        pulse_restart();
        fetch_pair(23'h7FFFF, 32'hAAAA_5555, 1'b0);
        step(3);
        chk("bwd_addr_after", {9'h0, flash_address}, 32'h7FFFE);

        // Wrap both ways
        dir = 1'b0;
        pulse_restart();
        fetch_pair(23'h7FFFF, 32'h1234_5678, 1'b1);
        step(3);
        chk("fwd_wrap_addr", {9'h0, flash_address}, 32'h0);
        fetch_pair(23'h0, 32'hCAFE_F00D, 1'b0);
        step(3);
        chk("bwd_wrap_addr", {9'h0, flash_address}, 32'h7FFFF);

        // Waitrequest stall with three ticks during the fetch
        dir = 1'b1;
        pulse_restart();
        rd_hi = 0;
        acc0 = acc_cnt;
        ovr0 = ovr_cnt;
        sv0 = sv_cnt;
        addr_moves = 0;
        rd_word = 32'h1111_2222;
        exp_addr_q.push_back(23'h0);
        exp_smp_q.push_back(16'h2222);
        exp_smp_q.push_back(16'h1111);
        waitreq = 1'b1;
        pulse_tick();
        pulse_tick();
        pulse_tick();
        for (int i = 0; i < 50; i++) begin
            if (rd_hi >= 5) break;
            step(1);
        end
        waitreq = 1'b0;
        sv_exp += 2;
        wait_sv("stall_sv");
        step(5);
        chk("stall_read_cycles", rd_hi, 6);
        chk("stall_addr_stable", addr_moves, 0);
        chk("stall_overruns", ovr_cnt - ovr0, 1);
        chk("stall_samples", sv_cnt - sv0, 2);
        chk("stall_reads", acc_cnt - acc0, 1);
        chk("stall_busy_end", {31'h0, busy}, 32'h0);

        // Pause: ten ticks, nothing happens except overruns
        acc0 = acc_cnt;
        ovr0 = ovr_cnt;
        sv0 = sv_cnt;
        play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_tick();
            step(1);
        end
        step(3);
        chk("pause_no_read", acc_cnt - acc0, 0);
        chk("pause_no_sample", sv_cnt - sv0, 0);
        chk("pause_addr", {9'h0, flash_address}, 32'h1);
        chk("pause_overruns", ovr_cnt - ovr0, 9);
        rd_word = 32'h3333_4444;
        exp_addr_q.push_back(23'h1);
        exp_smp_q.push_back(16'h4444);
        play = 1'b1;
        sv_exp++;
        wait_sv("resume_sv");
        step(10);
        chk("resume_one_read", acc_cnt - acc0, 1);
        chk("resume_one_sample", sv_cnt - sv0, 1);

        // Finish the word, then walk forward to 0x100
        exp_smp_q.push_back(16'h3333);
        pulse_tick();
        sv_exp++;
        wait_sv("resume_second_sv");
        pulse_restart();
        for (int i = 0; i < 256; i++) begin
            logic [15:0] lo;
            lo = 16'(i);
            fetch_pair(23'(i), {~lo, lo}, 1'b1);
        end
        step(2);
        chk("walk_addr", {9'h0, flash_address}, 32'h100);

        // Restart during WAIT_DATA discards the returning word
        sv0 = sv_cnt;
        acc0 = acc_cnt;
        rdv_extra = 3;
        rd_word = 32'hDEAD_0100;
        exp_addr_q.push_back(23'h100);
        pulse_tick();
        for (int i = 0; i < 50; i++) begin
            if (acc_cnt != acc0) break;
            step(1);
        end
        step(1);
        chk("rs_in_wait", {31'h0, busy & ~flash_read}, 32'h1);
        pulse_restart();
        step(10);
        chk("rs_no_sample", sv_cnt - sv0, 0);
        chk("rs_idle", {31'h0, busy}, 32'h0);
        chk("rs_addr", {9'h0, flash_address}, 32'h0);
        rdv_extra = 0;
        rd_word = 32'h0BAD_C0DE;
        exp_addr_q.push_back(23'h0);
        exp_smp_q.push_back(16'hC0DE);
        pulse_tick();
        sv_exp++;
        wait_sv("rs_next_sv");
        step(5);

        chk("left_samples", exp_smp_q.size(), 0);
        chk("left_reads", exp_addr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
